// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: assembles a big-endian 32-bit word from a
// byte-wide instruction memory and holds it for decode.
module fetch_sequencer #(
  parameter int          IM_DEPTH = 256,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] IM_Addr,
  input  logic [7:0]  IM_Data,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  input  logic        Instr_Ready,
  output logic        Instr_Valid,
  output logic [31:0] Instruction_Out,
  output logic [63:0] PC_Out,
  output logic        Fault,
  output logic [15:0] Fetch_Count
);

  typedef enum logic [2:0] {
    FETCH0, FETCH1, FETCH2, FETCH3, HOLD, FAULT
  } state_e;

  // Highest PC from which a full word can still be fetched.
  localparam logic [63:0] LAST_PC = 64'(IM_DEPTH - 4);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [23:0] asm_q;
  logic [31:0] instr_q;
  logic [63:0] pc_out_q;
  logic        valid_q;
  logic        fault_q;
  logic [15:0] count_q;

  logic        accept;
  logic        redirect;
  logic        target_bad;
  logic [63:0] seq_pc;
  logic        seq_bad;

  assign accept     = (state_q == HOLD) && Instr_Ready;
  assign redirect   = (state_q != FAULT) && Branch_Taken;
  assign target_bad = (Branch_Target[1:0] != 2'b00) || (Branch_Target > LAST_PC);
  assign seq_pc     = pc_q + 64'd4;
  assign seq_bad    = seq_pc > LAST_PC;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= FETCH0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/pc_d and no latch
  // is inferred.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      FETCH0: state_d = FETCH1;
      FETCH1: state_d = FETCH2;
      FETCH2: state_d = FETCH3;
      FETCH3: state_d = HOLD;
      HOLD: begin
        if (accept) begin
          pc_d    = seq_pc;
          state_d = seq_bad ? FAULT : FETCH0;
        end
      end
      FAULT:  state_d = FAULT;
      default: state_d = FAULT;
    endcase
    // A redirect overrides sequential flow; a simultaneous accept still counts.
    if (redirect) begin
      pc_d    = Branch_Target;
      state_d = target_bad ? FAULT : FETCH0;
    end
  end

  always_comb begin
    IM_Addr = pc_q;
    unique case (state_q)
      FETCH1:  IM_Addr = pc_q + 64'd1;
      FETCH2:  IM_Addr = pc_q + 64'd2;
      FETCH3:  IM_Addr = pc_q + 64'd3;
      default: IM_Addr = pc_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      asm_q    <= '0;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      unique case (state_q)
        FETCH0:  asm_q[23:16] <= IM_Data;
        FETCH1:  asm_q[15:8]  <= IM_Data;
        FETCH2:  asm_q[7:0]   <= IM_Data;
        default: asm_q        <= asm_q;
      endcase
      if (state_q == FETCH3 && state_d == HOLD) begin
        instr_q  <= {asm_q, IM_Data};
        pc_out_q <= pc_q;
      end
      valid_q <= (state_d == HOLD);
      fault_q <= (state_d == FAULT);
      if (accept && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  assign Instr_Valid     = valid_q;
  assign Instruction_Out = instr_q;
  assign PC_Out          = pc_out_q;
  assign Fault           = fault_q;
  assign Fetch_Count     = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte memory model plus a scoreboard of
// expected {instruction, pc} pairs popped whenever the DUT presents a word.
module tb_fetch_sequencer;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] IM_Addr;
  logic [7:0]  IM_Data;
  logic        Branch_Taken;
  logic [63:0] Branch_Target;
  logic        Instr_Ready;
  logic        Instr_Valid;
  logic [31:0] Instruction_Out;
  logic [63:0] PC_Out;
  logic        Fault;
  logic [15:0] Fetch_Count;

  logic [7:0] mem [0:255];
  exp_t       sb [$];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 CLK = ~CLK;

  assign IM_Data = (IM_Addr < 64'd256) ? mem[IM_Addr[7:0]] : 8'h00;

  fetch_sequencer #(.IM_DEPTH(256), .RESET_PC(64'h0)) dut (
    .CLK(CLK), .Reset(Reset), .IM_Addr(IM_Addr), .IM_Data(IM_Data),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Instr_Ready(Instr_Ready), .Instr_Valid(Instr_Valid),
    .Instruction_Out(Instruction_Out), .PC_Out(PC_Out),
    .Fault(Fault), .Fetch_Count(Fetch_Count)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic push_exp(input int a);
    exp_t e;
    e.instr = word_at(a);
    e.pc    = 64'(a);
    sb.push_back(e);
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (!Instr_Valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 64'(Instr_Valid), 64'd1);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    check({tag, "_sb_size"}, 64'(sb.size()), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_instr"}, 64'(Instruction_Out), 64'(e.instr));
      check({tag, "_pc"}, PC_Out, e.pc);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] held;
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
    mem[0] = 8'hF8; mem[1] = 8'h40; mem[2] = 8'h83; mem[3] = 8'hE1;
    Reset = 1'b1; Branch_Taken = 1'b0; Branch_Target = '0; Instr_Ready = 1'b0;
    tick();
    tick();

    // Reset state; FETCH0 cycle is the first one after release.
    check("rst_valid", 64'(Instr_Valid), 64'd0);
    check("rst_instr", 64'(Instruction_Out), 64'd0);
    check("rst_pc_out", PC_Out, 64'd0);
    check("rst_fault", 64'(Fault), 64'd0);
    check("rst_count", 64'(Fetch_Count), 64'd0);
    Reset = 1'b0;
    push_exp(0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s1_addr%0d", k), IM_Addr, 64'(k));
      check($sformatf("s1_novalid%0d", k), 64'(Instr_Valid), 64'd0);
      tick();
    end
    check("s1_valid_4th", 64'(Instr_Valid), 64'd1);
    pop_compare("s1");
    check("s1_literal", 64'(Instruction_Out), 64'h0000_0000_F840_83E1);

    // HOLD stability with decode stalled.
    held = Instruction_Out;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("s2_hold_valid%0d", k), 64'(Instr_Valid), 64'd1);
      check($sformatf("s2_hold_instr%0d", k), 64'(Instruction_Out), 64'(held));
      check($sformatf("s2_hold_pc%0d", k), PC_Out, 64'd0);
    end
    Instr_Ready = 1'b1;
    tick();
    Instr_Ready = 1'b0;
    check("s2_count", 64'(Fetch_Count), 64'd1);
    check("s2_next_addr", IM_Addr, 64'd4);
    check("s2_valid_clr", 64'(Instr_Valid), 64'd0);
    push_exp(4);
    wait_valid("s2", n);
    check("s2_latency", 64'(n), 64'd4);
    pop_compare("s2");

    // Redirect during FETCH2 drops the partial word.
    Instr_Ready = 1'b1;
    tick();
    Instr_Ready = 1'b0;
    tick();
    tick();
    check("s3_in_fetch2", IM_Addr, 64'd10);
    Branch_Taken = 1'b1; Branch_Target = 64'd48;
    push_exp(48);
    tick();
    Branch_Taken = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("s3_addr%0d", k), IM_Addr, 64'(48 + k));
      check($sformatf("s3_novalid%0d", k), 64'(Instr_Valid), 64'd0);
      tick();
    end
    pop_compare("s3");
    check("s3_count", 64'(Fetch_Count), 64'd2);

    // Accept and redirect in the same cycle.
    Branch_Taken = 1'b1; Branch_Target = 64'd100; Instr_Ready = 1'b1;
    tick();
    Branch_Taken = 1'b0; Instr_Ready = 1'b0;
    check("s4_count", 64'(Fetch_Count), 64'd3);
    check("s4_addr", IM_Addr, 64'd100);
    check("s4_valid_clr", 64'(Instr_Valid), 64'd0);
    push_exp(100);
    wait_valid("s4", n);
    pop_compare("s4");

    // Misaligned target faults; fault ignores branch and ready.
    Branch_Taken = 1'b1; Branch_Target = 64'd50;
    tick();
    Branch_Target = 64'd0;
    for (int k = 0; k < 20; k++) begin
      Instr_Ready = k[0];
      check($sformatf("s5_fault%0d", k), 64'(Fault), 64'd1);
      check($sformatf("s5_novalid%0d", k), 64'(Instr_Valid), 64'd0);
      check($sformatf("s5_addr%0d", k), IM_Addr, 64'd50);
      tick();
    end
    check("s5_count_frozen", 64'(Fetch_Count), 64'd3);
    Branch_Taken = 1'b0; Instr_Ready = 1'b0;
    do_reset();
    check("s5_rst_fault", 64'(Fault), 64'd0);
    check("s5_rst_addr", IM_Addr, 64'd0);
    check("s5_rst_count", 64'(Fetch_Count), 64'd0);

    // Out-of-range target faults.
    push_exp(0);
    wait_valid("s5b", n);
    pop_compare("s5b");
    Branch_Taken = 1'b1; Branch_Target = 64'd300;
    tick();
    Branch_Taken = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("s5b_fault%0d", k), 64'(Fault), 64'd1);
      check($sformatf("s5b_addr%0d", k), IM_Addr, 64'd300);
      tick();
    end
    do_reset();

    // Sequential accept at the last word faults.
    Branch_Taken = 1'b1; Branch_Target = 64'd252;
    tick();
    Branch_Taken = 1'b0;
    check("s6_addr252", IM_Addr, 64'd252);
    push_exp(252);
    wait_valid("s6", n);
    pop_compare("s6");
    Instr_Ready = 1'b1;
    tick();
    Instr_Ready = 1'b0;
    check("s6_fault", 64'(Fault), 64'd1);
    check("s6_novalid", 64'(Instr_Valid), 64'd0);
    check("s6_count", 64'(Fetch_Count), 64'd1);
    check("s6_fault_addr", IM_Addr, 64'd256);
    do_reset();
    check("s6_rst_fault", 64'(Fault), 64'd0);

    // Reset in FETCH1 overrides a concurrent branch.
    tick();
    check("s7_in_fetch1", IM_Addr, 64'd1);
    Reset = 1'b1; Branch_Taken = 1'b1; Branch_Target = 64'd48;
    tick();
    Reset = 1'b0; Branch_Taken = 1'b0;
    check("s7_addr", IM_Addr, 64'd0);
    check("s7_novalid", 64'(Instr_Valid), 64'd0);
    tick();
    check("s7_resume", IM_Addr, 64'd1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
